// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Also holds the counter-width helper used by seq_divider.
package seq_divider_pkg;

   // Controller states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DIVIDEND_W_DEF = 8;
   localparam int DIVISOR_W_DEF  = 4;

   // Bit counter width for a given dividend width (counts 0 .. DIVIDEND_W-1)
   function automatic int cnt_width(input int dividend_w);
      return (dividend_w <= 2) ? 1 : $clog2(dividend_w);
   endfunction

   localparam int CNT_W_DEF = cnt_width(DIVIDEND_W_DEF);

endpackage

// File: rtl/seq_divider_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep or restore.
// Purely combinational; instantiated once by seq_divider.
module div_step #(
   parameter int DIVISOR_W = 4
) (
   input  logic [DIVISOR_W:0]   rem_in,
   input  logic                 bit_in,
   input  logic [DIVISOR_W-1:0] divisor,
   output logic [DIVISOR_W:0]   rem_out,
   output logic                 q_bit
);

   logic [DIVISOR_W+1:0] shifted;
   logic [DIVISOR_W+1:0] trial;

   // Shift in the next bit, then subtract; the MSB of the trial is its sign
   always_comb begin
      shifted = {rem_in, bit_in};
      trial   = shifted - {2'b00, divisor};
      q_bit   = ~trial[DIVISOR_W+1];
      rem_out = q_bit ? trial[DIVISOR_W:0] : shifted[DIVISOR_W:0];
   end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock,
// start/done handshake. Divide-by-zero short-circuits to DONE.
// Optional macro SEQ_DIVIDER_SIGNED_EN: two's-complement operands; the core
// runs on magnitudes and the signs are re-applied when the result registers.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int DIVIDEND_W = DIVIDEND_W_DEF,
   parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  busy,
   output logic                  done,
   output logic                  div_by_zero
);

   localparam int CNT_W = cnt_width(DIVIDEND_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DIVIDEND_W - 1);

   state_t state;
   state_t state_next;

   // Working registers
   logic [DIVISOR_W:0]    prem;
   logic [DIVIDEND_W-1:0] shreg;
   logic [DIVISOR_W-1:0]  dvsr;
   logic [CNT_W-1:0]      cnt;

   // Step results and operand/result conditioning
   logic [DIVISOR_W:0]    prem_next;
   logic                  q_bit;
   logic [DIVIDEND_W-1:0] q_raw;
   logic [DIVISOR_W-1:0]  r_raw;
   logic [DIVIDEND_W-1:0] q_fix;
   logic [DIVISOR_W-1:0]  r_fix;
   logic [DIVIDEND_W-1:0] dvd_mag;
   logic [DIVISOR_W-1:0]  dvs_mag;
   logic                  accept;
   logic                  zero_div;
   logic                  last_bit;

`ifdef SEQ_DIVIDER_SIGNED_EN
   logic q_neg;
   logic r_neg;
`endif

   assign accept   = (state == IDLE) && start;
   assign zero_div = (divisor == '0);
   assign last_bit = (state == BUSY) && (cnt == LAST_BIT);

   div_step #(
      .DIVISOR_W (DIVISOR_W)
   ) u_step (
      .rem_in  (prem),
      .bit_in  (shreg[DIVIDEND_W-1]),
      .divisor (dvsr),
      .rem_out (prem_next),
      .q_bit   (q_bit)
   );

   assign q_raw = {shreg[DIVIDEND_W-2:0], q_bit};
   assign r_raw = prem_next[DIVISOR_W-1:0];

`ifdef SEQ_DIVIDER_SIGNED_EN
   // Magnitudes at acceptance; the most-negative value maps to its unsigned twin
   always_comb begin
      dvd_mag = dividend[DIVIDEND_W-1] ? (~dividend + 1'b1) : dividend;
      dvs_mag = divisor[DIVISOR_W-1]   ? (~divisor + 1'b1)  : divisor;
   end

   // Sign fix-up: quotient negative on sign mismatch, remainder follows dividend
   always_comb begin
      q_fix = q_neg ? (~q_raw + 1'b1) : q_raw;
      r_fix = r_neg ? (~r_raw + 1'b1) : r_raw;
   end
`else
   assign dvd_mag = dividend;
   assign dvs_mag = divisor;
   assign q_fix   = q_raw;
   assign r_fix   = r_raw;
`endif

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state logic; a zero divisor skips the iteration entirely
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = zero_div ? DONE : BUSY;
            end
         end
         BUSY: begin
            if (cnt == LAST_BIT) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs decoded from the current state
   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   // Working registers: load on acceptance, iterate while BUSY
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prem  <= '0;
         shreg <= '0;
         dvsr  <= '0;
         cnt   <= '0;
      end else if (accept) begin
         prem  <= '0;
         shreg <= dvd_mag;
         dvsr  <= dvs_mag;
         cnt   <= '0;
      end else if (state == BUSY) begin
         prem  <= prem_next;
         shreg <= q_raw;
         cnt   <= cnt + 1'b1;
      end
   end

`ifdef SEQ_DIVIDER_SIGNED_EN
   // Result signs captured from the raw operands at acceptance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_neg <= 1'b0;
         r_neg <= 1'b0;
      end else if (accept) begin
         q_neg <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
         r_neg <= dividend[DIVIDEND_W-1];
      end
   end
`endif

   // Result registers: written only on completion, held otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (accept && zero_div) begin
         quotient    <= '1;
         remainder   <= dividend[DIVISOR_W-1:0];
         div_by_zero <= 1'b1;
      end else if (last_bit) begin
         quotient    <= q_fix;
         remainder   <= r_fix;
         div_by_zero <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results with the
// cycle on which done must appear; a monitor pops them on every done pulse.
// Honours SEQ_DIVIDER_SIGNED_EN for the signed expectations.
module tb_seq_divider;

   localparam int W = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] dividend;
   logic [3:0] divisor;
   logic [7:0] quotient;
   logic [3:0] remainder;
   logic       busy;
   logic       done;
   logic       div_by_zero;

   typedef struct {
      logic [7:0] q;
      logic [3:0] r;
      logic       z;
      int         at;
      int         id;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   int   next_id = 0;

   seq_divider dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model with the same truncation rules as the build
   function automatic exp_t model(input logic [7:0] a, input logic [3:0] b);
      exp_t e;
      int   qi;
      int   ri;
      e.at = 0;
      e.id = 0;
      if (b == 4'd0) begin
         e.q = 8'hFF;
         e.r = a[3:0];
         e.z = 1'b1;
      end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
         qi = int'($signed(a)) / int'($signed(b));
         ri = int'($signed(a)) % int'($signed(b));
`else
         qi = int'(a) / int'(b);
         ri = int'(a) % int'(b);
`endif
         e.q = qi[7:0];
         e.r = ri[3:0];
         e.z = 1'b0;
      end
      return e;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      exp_t e;
      if (!rst && done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
         end else begin
            e = sb.pop_front();
            check($sformatf("quotient#%0d", e.id), 32'(quotient), 32'(e.q));
            check($sformatf("remainder#%0d", e.id), 32'(remainder), 32'(e.r));
            check($sformatf("div_by_zero#%0d", e.id), 32'(div_by_zero), 32'(e.z));
            check($sformatf("done_cycle#%0d", e.id), 32'(cyc), 32'(e.at));
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: got busy=1 expected busy=0 within 100 cycles");
      end
   endtask

   function automatic void push_exp(input logic [7:0] q, input logic [3:0] r, input logic z,
                                    input logic [3:0] b);
      exp_t e;
      e.q  = q;
      e.r  = r;
      e.z  = z;
      e.at = cyc + 1 + ((b == 4'd0) ? 0 : W);
      e.id = next_id;
      next_id++;
      sb.push_back(e);
   endfunction

   // Issue one division from IDLE; returns the number of cycles busy was high
   task automatic issue(input logic [7:0] a, input logic [3:0] b,
                        input logic [7:0] q, input logic [3:0] r, input logic z,
                        output int bcycles);
      wait_idle();
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      push_exp(q, r, z, b);
      @(negedge clk);
      start    = 1'b0;
      dividend = 8'($urandom);
      divisor  = 4'($urandom);
      bcycles  = 0;
      while (busy && bcycles < 100) begin
         bcycles++;
         @(negedge clk);
      end
   endtask

   task automatic issue_model(input logic [7:0] a, input logic [3:0] b);
      exp_t e;
      int   bc;
      e = model(a, b);
      issue(a, b, e.q, e.r, e.z, bc);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   logic [7:0] ta [7] = '{8'd200, 8'd13, 8'd9, 8'd255, 8'd0, 8'd5, 8'd77};
   logic [3:0] tb [7] = '{4'd7, 4'd0, 4'd3, 4'd1, 4'd15, 4'd15, 4'd6};

   initial begin
      int bc;
      int m_cnt;
      int n;
      exp_t e;

      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(negedge clk);
      check("rst_quotient", 32'(quotient), 32'd0);
      check("rst_remainder", 32'(remainder), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_div_by_zero", 32'(div_by_zero), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // 200/7 with latency and busy-width checks
`ifdef SEQ_DIVIDER_SIGNED_EN
      issue(8'd200, 4'd7, 8'hF8, 4'h0, 1'b0, bc);     // -56/7 = -8 r 0
`else
      issue(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, bc);
`endif
      check("busy_cycles_200_7", 32'(bc), 32'd9);

      // Reset while BUSY with counter at 3
      wait_idle();
      dividend = 8'd200;
      divisor  = 4'd7;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_quotient", 32'(quotient), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Divide by zero, result hold, then a normal division
      issue(8'd13, 4'd0, 8'hFF, 4'hD, 1'b1, bc);
      check("busy_cycles_13_0", 32'(bc), 32'd1);
      repeat (3) @(negedge clk);
      check("hold_quotient", 32'(quotient), 32'hFF);
      check("hold_div_by_zero", 32'(div_by_zero), 32'd1);
      issue(8'd9, 4'd3, 8'd3, 4'd0, 1'b0, bc);

      // Boundaries
      issue(8'd255, 4'd1, 8'd255, 4'd0, 1'b0, bc);    // signed: -1/1 = -1 r 0
      issue(8'd0, 4'd15, 8'd0, 4'd0, 1'b0, bc);
`ifdef SEQ_DIVIDER_SIGNED_EN
      issue(8'd5, 4'd15, 8'hFB, 4'd0, 1'b0, bc);      // 5/-1 = -5 r 0
      issue(8'h9C, 4'h7, 8'hF2, 4'hE, 1'b0, bc);      // -100/7 = -14 r -2
      issue(8'd100, 4'h9, 8'hF2, 4'h2, 1'b0, bc);     // 100/-7 = -14 r 2
      issue(8'h80, 4'hF, 8'h80, 4'h0, 1'b0, bc);      // -128/-1 wraps
`else
      issue(8'd5, 4'd15, 8'd0, 4'd5, 1'b0, bc);
      issue(8'd100, 4'd7, 8'd14, 4'd2, 1'b0, bc);
`endif

      // start held high for 30 cycles with operands changing every cycle
      wait_idle();
      m_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         dividend = ta[i % 7];
         divisor  = tb[i % 7];
         start    = 1'b1;
         if (m_cnt == 0) begin
            e = model(dividend, divisor);
            push_exp(e.q, e.r, e.z, divisor);
            m_cnt = (divisor == 4'd0) ? 1 : W + 1;
         end else begin
            m_cnt--;
         end
         @(negedge clk);
      end
      start = 1'b0;
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("held_start_drained", 32'(sb.size()), 32'd0);

`ifdef SEQ_DIVIDER_SIGNED_EN
      for (int i = 0; i < 1000; i++) begin
         issue_model(8'($urandom), 4'($urandom));
      end
`endif

      wait_idle();
      repeat (3) @(negedge clk);
      check("final_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle restoring shift-subtract divider; the inverse operation of the team's 4x4 array multiplier.
- Divides an 8-bit dividend by a 4-bit divisor and returns quotient and remainder.
- Produces one quotient bit per clock, with a start/done handshake.
- Sits in the ALU beside the multiplier; the ALU op decoder drives start and muxes the results.

Parameters:
- DIVIDEND_W, 8, dividend and quotient width (>=2).
- DIVISOR_W, 4, divisor and remainder width (>=2, <=DIVIDEND_W).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  DIVIDEND_W  numerator; latched when start is accepted.
- divisor  input  DIVISOR_W  denominator; latched when start is accepted.
- quotient  output  DIVIDEND_W  registered result.
- remainder  output  DIVISOR_W  registered result.
- busy  output  1  high whenever state != IDLE.
- done  output  1  single-cycle completion pulse.
- div_by_zero  output  1  registered; set with a result whose divisor was 0.

Behaviour:
- Reset: rst is asynchronous and active-high. On assertion, state=IDLE and quotient, remainder, busy, done, div_by_zero are all 0. Reset mid-operation aborts the division; no done pulse is produced.
- States: IDLE, BUSY, DONE.
- IDLE:
  - On an edge with start=1, latch the operands.
  - Clear the working registers: partial remainder (DIVISOR_W+1 bits) = 0, shift register = dividend, bit counter = 0.
  - Go to BUSY.
  - If the latched divisor == 0, go directly to DONE instead. Result: quotient = all ones, remainder = dividend[DIVISOR_W-1:0], div_by_zero = 1.
- BUSY, once per edge:
  - Shift {partial remainder, shift register} left by 1.
  - Trial-subtract the divisor. If the result is non-negative, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
  - Increment the counter.
  - On the edge that processes the last bit (counter == DIVIDEND_W-1), register quotient/remainder, set div_by_zero = 0, and go to DONE.
- DONE: done=1 for exactly this one cycle; next edge returns to IDLE.
- Latency: start sampled at edge N.
  - Normal case: done is high between edges N+DIVIDEND_W and N+DIVIDEND_W+1.
  - Divide-by-zero case: done is high between edges N and N+1.
- Start handling: start is ignored in BUSY and DONE. There is no queuing; the requester must wait for busy=0.
- Input stability: operand inputs may change freely after acceptance.
- Result hold: quotient, remainder and div_by_zero hold their value until the next completed division or reset.
- Arithmetic (unsigned build):
  - Exact identity dividend = quotient*divisor + remainder.
  - remainder < divisor.
  - quotient is never truncated.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- Defined (two's-complement mode):
  - Operands are signed two's complement; magnitudes are taken at acceptance and the core runs unsigned.
  - Quotient truncates toward zero.
  - Remainder carries the dividend's sign; its magnitude is < |divisor|.
  - Sign fix-up (negation) is applied when the result is registered; latency is unchanged.
  - Overflow case (most-negative dividend / -1) wraps: quotient = most-negative value (0x80 for W=8), remainder 0.
  - Divide-by-zero result unchanged from unsigned.
- Undefined: unsigned only; no extra logic.

Decomposition:
- Package seq_divider_pkg:
  - State enum (IDLE, BUSY, DONE).
  - Default width constants DIVIDEND_W_DEF=8, DIVISOR_W_DEF=4.
  - Counter width constant clog2(DIVIDEND_W).
- One sub-module, div_step: combinational shift + trial subtract + restore.
  - Inputs: partial remainder, incoming bit, divisor.
  - Outputs: next partial remainder, quotient bit.
- The top level holds the FSM, counter, operand/result registers, and signed fix-up.

Test Plan:
- Reset, no stimulus -> all outputs 0, busy=0. Assert rst during BUSY at counter=3 -> busy falls asynchronously, no done, next start divides normally.
- 200/7 -> done exactly 8 cycles after the accepting edge; quotient=28, remainder=4, div_by_zero=0; busy high for 9 cycles including DONE.
- 13/0 -> done on the cycle after acceptance; quotient=0xFF, remainder=0xD, div_by_zero=1. A following 9/3 -> quotient=3, remainder=0, div_by_zero=0.
- Boundaries -> 255/1 gives q=255, r=0; 0/15 gives q=0, r=0; 5/15 gives q=0, r=5.
- start held high continuously for 30 cycles with operand changes while BUSY -> results reflect only the operands latched at each IDLE acceptance; a new acceptance occurs on the cycle after each DONE.
- SEQ_DIVIDER_SIGNED_EN defined:
  - -100/7 -> q=-14, r=-2.
  - 100/-7 -> q=-14, r=2.
  - -128/-1 -> q=-128 (0x80), r=0.
  - Random 1000-vector compare against a reference model with the same truncation rules.
